core_test_monitor: RTL and testbench
====================================

Name: core_test_monitor

Overview:
- Synthesizable, parametrised successor to the directed pipeline bench.
- Snoops the core's writeback/retire port and keeps a shadow register file.
- Detects program end (ecall/ebreak retire or a self-loop at the same PC), waits for the pipeline to drain, then checks a loadable table of expected register values.
- Reports pass/fail, counters, timeout and the first mismatch; usable in simulation and on FPGA.

Parameters:
- XLEN, 32, data/PC width
- NUM_REGS, 32, architectural registers mirrored (x0 hardwired 0)
- NUM_CHECKS, 16, expectation table entries
- TIMEOUT_CYCLES, 10000, RUN-state cycle limit
- DRAIN_CYCLES, 8, cycles after halt during which writebacks are still captured
- CNT_W, 32, width of cycle/retire counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  begin a run; accepted only in IDLE or DONE
- wb_valid  in  1  an instruction retires this cycle
- wb_pc  in  XLEN  PC of the retiring instruction
- wb_we  in  1  the retiring instruction writes rd
- wb_rd  in  $clog2(NUM_REGS)  destination register
- wb_data  in  XLEN  writeback value
- wb_halt  in  1  the retiring instruction is ecall/ebreak
- exp_we  in  1  write an expectation entry; accepted only in IDLE or DONE
- exp_idx  in  $clog2(NUM_CHECKS)  table index
- exp_rd  in  $clog2(NUM_REGS)  register to check
- exp_val  in  XLEN  expected value
- exp_en  in  1  entry valid bit (0 disables the entry)
- done  out  1  results are final
- pass  out  1  done, no timeout and fail_count == 0
- timeout  out  1  run exceeded TIMEOUT_CYCLES
- pass_count  out  $clog2(NUM_CHECKS+1)  entries that matched
- fail_count  out  $clog2(NUM_CHECKS+1)  entries that mismatched
- first_fail_idx  out  $clog2(NUM_CHECKS)  lowest failing index
- first_fail_actual  out  XLEN  shadow value at first_fail_idx
- cycle_count  out  CNT_W  cycles spent in RUN + DRAIN
- retire_count  out  CNT_W  wb_valid pulses seen in RUN + DRAIN

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0. Shadow registers 0. Expectation valid bits 0.
- FSM: IDLE -> RUN on start.
  - RUN -> DRAIN on halt.
  - RUN -> DONE on timeout.
  - DRAIN -> CHECK after DRAIN_CYCLES cycles.
  - CHECK -> DONE after NUM_CHECKS cycles.
  - DONE -> RUN on start.
- Halt condition in RUN: wb_valid && (wb_halt || (last_pc_valid && wb_pc == last_pc)). last_pc updates on every wb_valid; last_pc_valid is cleared on start.
- Start (IDLE/DONE), effective next edge:
  - clears shadow regs, counters, done, pass, timeout, pass/fail counts, first_fail_*, last_pc_valid;
  - keeps the expectation table;
  - start in RUN, DRAIN or CHECK is ignored.
- Shadow write: in RUN or DRAIN, when wb_valid && wb_we && wb_rd != 0, shadow[wb_rd] <= wb_data.
  - Writes to x0 are dropped; x0 always reads 0.
  - wb_* is ignored in IDLE, CHECK and DONE.
- Counters:
  - cycle_count increments every RUN/DRAIN cycle.
  - retire_count increments on wb_valid in RUN/DRAIN.
  - Both saturate at all-ones; no wrap.
- Timeout: checked in RUN only. If cycle_count reaches TIMEOUT_CYCLES-1 with no halt, the next state is DONE with timeout=1, pass=0, and no CHECK is performed.
- Halt and timeout in the same cycle: halt wins.
- DRAIN: captures writebacks; a further halt in DRAIN is ignored.
- CHECK: index i runs 0..NUM_CHECKS-1, one entry per cycle.
  - If entry i is valid: compare shadow[exp_rd] to exp_val, incrementing pass_count or fail_count.
  - On the first mismatch only: latch first_fail_idx=i and first_fail_actual.
  - Invalid entries consume a cycle with no count change.
- DONE:
  - done=1 and pass registered in the same edge as the DONE entry.
  - All outputs hold until the next start or reset.
  - pass=0 if no entry is valid (an empty table is not a pass).
- Expectation writes in IDLE/DONE take effect on the next edge; in other states they are ignored.
- Latency: halt retire -> done = DRAIN_CYCLES + NUM_CHECKS + 1 cycles.
- Reset mid-run: immediate return to IDLE; the table is cleared.

Decomposition:
- riscv_pkg additions:
  - monitor state enum (MON_IDLE, MON_RUN, MON_DRAIN, MON_CHECK, MON_DONE);
  - expectation entry struct {en, rd, val};
  - default TIMEOUT/DRAIN constants.
- Sub-module: core_test_monitor_shadow_rf. Single write port, one combinational read port for CHECK, synchronous clear on start, x0 forced to 0.

Test Plan:
1. Program writes x5=10, x6=20, x7=30, x8=10, then ecall; table x5=10, x6=20, x7=30, x8=10 -> done=1, pass=1, pass_count=4, fail_count=0.
2. Same run with entry 2 expecting x7=31 -> pass=0, fail_count=1, first_fail_idx=2, first_fail_actual=30.
3. Self-loop: retire pc 0x40 twice consecutively, with x29=170 written 3 cycles after the second retire (inside DRAIN) -> x29 check passes; a write after DRAIN expires is not captured.
4. TIMEOUT_CYCLES=50, no halt -> done=1, timeout=1, pass=0, cycle_count=50, pass_count=0.
5. Write to x0 with 0xDEADBEEF and table x0=0 -> pass; start asserted during CHECK is ignored and results are unchanged.
6. Assert reset during DRAIN -> all outputs 0 and state IDLE; a restart without reloading the table -> done with pass=0 (empty table).

Source files
------------

// File: rtl/core_test_monitor_pkg.sv
// Shared state encoding and default timing constants for the core test monitor.
package core_test_monitor_pkg;

    typedef enum logic [2:0] {
        MON_IDLE,
        MON_RUN,
        MON_DRAIN,
        MON_CHECK,
        MON_DONE
    } mon_state_e;

    localparam int MON_DEFAULT_TIMEOUT = 10000;
    localparam int MON_DEFAULT_DRAIN   = 8;

endpackage

// File: rtl/core_test_monitor_shadow_rf.sv
// Shadow copy of the architectural register file, fed from the retire port.
module core_test_monitor_shadow_rf
    import core_test_monitor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] waddr,
    input  logic [XLEN-1:0]             wdata,
    input  logic [$clog2(NUM_REGS)-1:0] raddr,
    output logic [XLEN-1:0]             rdata
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    // NOTE: built from flops rather than RAM on purpose: both the async reset
    // and the one-cycle clear on start must zero every entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    // x0 is hardwired; the read mux never looks at entry 0.
    assign rdata = (raddr == '0) ? '0 : regs_q[raddr];

endmodule

// File: rtl/core_test_monitor.sv
// Retire-port monitor: detects program end, drains, then scores the shadow
// register file against a loadable expectation table.
module core_test_monitor
    import core_test_monitor_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_CHECKS     = 16,
    parameter int TIMEOUT_CYCLES = MON_DEFAULT_TIMEOUT,
    parameter int DRAIN_CYCLES   = MON_DEFAULT_DRAIN,
    parameter int CNT_W          = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            wb_valid,
    input  logic [XLEN-1:0]                 wb_pc,
    input  logic                            wb_we,
    input  logic [$clog2(NUM_REGS)-1:0]     wb_rd,
    input  logic [XLEN-1:0]                 wb_data,
    input  logic                            wb_halt,
    input  logic                            exp_we,
    input  logic [$clog2(NUM_CHECKS)-1:0]   exp_idx,
    input  logic [$clog2(NUM_REGS)-1:0]     exp_rd,
    input  logic [XLEN-1:0]                 exp_val,
    input  logic                            exp_en,
    output logic                            done,
    output logic                            pass,
    output logic                            timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0] pass_count,
    output logic [$clog2(NUM_CHECKS+1)-1:0] fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0]   first_fail_idx,
    output logic [XLEN-1:0]                 first_fail_actual,
    output logic [CNT_W-1:0]                cycle_count,
    output logic [CNT_W-1:0]                retire_count
);

    localparam int RW = $clog2(NUM_REGS);
    localparam int IW = $clog2(NUM_CHECKS);
    localparam int CW = $clog2(NUM_CHECKS + 1);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0]    DRAIN_LAST   = DW'(DRAIN_CYCLES - 1);
    localparam logic [IW-1:0]    CHECK_LAST   = IW'(NUM_CHECKS - 1);

    typedef struct packed {
        logic            en;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] val;
    } exp_entry_t;

    mon_state_e state_q, state_d;

    exp_entry_t      table_q [NUM_CHECKS];
    exp_entry_t      cur_entry;
    logic [XLEN-1:0] shadow_rdata;

    logic [XLEN-1:0]  last_pc_q;
    logic             last_pc_valid_q;
    logic [DW-1:0]    drain_cnt_q;
    logic [IW-1:0]    chk_idx_q;
    logic             done_q, pass_q, timeout_q;
    logic [CW-1:0]    pass_count_q, fail_count_q;
    logic [IW-1:0]    first_fail_idx_q;
    logic [XLEN-1:0]  first_fail_actual_q;
    logic [CNT_W-1:0] cycle_count_q, retire_count_q;

    logic wb_active, idle_or_done, halt_hit;
    logic start_ok, timeout_hit, entry_hit, entry_miss, pass_final;

    assign wb_active    = (state_q == MON_RUN) || (state_q == MON_DRAIN);
    assign idle_or_done = (state_q == MON_IDLE) || (state_q == MON_DONE);
    assign halt_hit     = wb_valid && (wb_halt || (last_pc_valid_q && wb_pc == last_pc_q));

    assign cur_entry  = table_q[chk_idx_q];
    assign entry_hit  = cur_entry.en && (shadow_rdata == cur_entry.val);
    assign entry_miss = cur_entry.en && (shadow_rdata != cur_entry.val);
    // Final verdict folds in the entry scored on the last CHECK cycle; empty tables never pass.
    assign pass_final = (fail_count_q == '0) && !entry_miss && ((pass_count_q != '0) || entry_hit);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= MON_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        start_ok    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            MON_IDLE, MON_DONE: begin
                if (start) begin
                    state_d  = MON_RUN;
                    start_ok = 1'b1;
                end
            end
            MON_RUN: begin
                if (halt_hit) begin
                    state_d = MON_DRAIN;
                end else if (cycle_count_q >= TIMEOUT_LAST) begin
                    state_d     = MON_DONE;
                    timeout_hit = 1'b1;
                end
            end
            MON_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = MON_CHECK;
            end
            MON_CHECK: begin
                if (chk_idx_q == CHECK_LAST) state_d = MON_DONE;
            end
            default: state_d = MON_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) table_q[i] <= '0;
        end else if (exp_we && idle_or_done) begin
            table_q[exp_idx] <= '{en: exp_en, rd: exp_rd, val: exp_val};
        end
    end

    core_test_monitor_shadow_rf #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_shadow_rf (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .we    (wb_active && wb_valid && wb_we),
        .waddr (wb_rd),
        .wdata (wb_data),
        .raddr (cur_entry.rd),
        .rdata (shadow_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc_q           <= '0;
            last_pc_valid_q     <= 1'b0;
            drain_cnt_q         <= '0;
            chk_idx_q           <= '0;
            done_q              <= 1'b0;
            pass_q              <= 1'b0;
            timeout_q           <= 1'b0;
            pass_count_q        <= '0;
            fail_count_q        <= '0;
            first_fail_idx_q    <= '0;
            first_fail_actual_q <= '0;
            cycle_count_q       <= '0;
            retire_count_q      <= '0;
        end else if (start_ok) begin
            last_pc_valid_q     <= 1'b0;
            drain_cnt_q         <= '0;
            chk_idx_q           <= '0;
            done_q              <= 1'b0;
            pass_q              <= 1'b0;
            timeout_q           <= 1'b0;
            pass_count_q        <= '0;
            fail_count_q        <= '0;
            first_fail_idx_q    <= '0;
            first_fail_actual_q <= '0;
            cycle_count_q       <= '0;
            retire_count_q      <= '0;
        end else begin
            if (wb_active) begin
                if (cycle_count_q != {CNT_W{1'b1}}) cycle_count_q <= cycle_count_q + CNT_W'(1);
                if (wb_valid) begin
                    if (retire_count_q != {CNT_W{1'b1}}) retire_count_q <= retire_count_q + CNT_W'(1);
                    last_pc_q       <= wb_pc;
                    last_pc_valid_q <= 1'b1;
                end
            end
            if (state_q == MON_DRAIN) drain_cnt_q <= drain_cnt_q + DW'(1);
            if (state_q == MON_CHECK) begin
                chk_idx_q <= chk_idx_q + IW'(1);
                if (entry_hit) pass_count_q <= pass_count_q + CW'(1);
                if (entry_miss) begin
                    fail_count_q <= fail_count_q + CW'(1);
                    if (fail_count_q == '0) begin
                        first_fail_idx_q    <= chk_idx_q;
                        first_fail_actual_q <= shadow_rdata;
                    end
                end
                if (state_d == MON_DONE) begin
                    done_q <= 1'b1;
                    pass_q <= pass_final;
                end
            end
            if (timeout_hit) begin
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end

    assign done              = done_q;
    assign pass              = pass_q;
    assign timeout           = timeout_q;
    assign pass_count        = pass_count_q;
    assign fail_count        = fail_count_q;
    assign first_fail_idx    = first_fail_idx_q;
    assign first_fail_actual = first_fail_actual_q;
    assign cycle_count       = cycle_count_q;
    assign retire_count      = retire_count_q;

endmodule

// File: tb/tb_core_test_monitor.sv
// Self-checking bench: directed scenarios plus random programs scored by a per-run reference model.
module tb_core_test_monitor;

    localparam int XLEN           = 32;
    localparam int NUM_REGS       = 32;
    localparam int NUM_CHECKS     = 16;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int DRAIN_CYCLES   = 8;
    localparam int CNT_W          = 32;
    localparam int RW             = $clog2(NUM_REGS);
    localparam int IW             = $clog2(NUM_CHECKS);
    localparam int CW             = $clog2(NUM_CHECKS + 1);
    localparam int MAXC           = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            wb_valid, wb_we, wb_halt;
    logic [XLEN-1:0] wb_pc, wb_data;
    logic [RW-1:0]   wb_rd;
    logic            exp_we, exp_en;
    logic [IW-1:0]   exp_idx;
    logic [RW-1:0]   exp_rd;
    logic [XLEN-1:0] exp_val;
    logic            done, pass, timeout;
    logic [CW-1:0]   pass_count, fail_count;
    logic [IW-1:0]   first_fail_idx;
    logic [XLEN-1:0] first_fail_actual;
    logic [CNT_W-1:0] cycle_count, retire_count;

    core_test_monitor #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_CHECKS(NUM_CHECKS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_halt(wb_halt),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_rd(exp_rd), .exp_val(exp_val), .exp_en(exp_en),
        .done(done), .pass(pass), .timeout(timeout),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_actual(first_fail_actual),
        .cycle_count(cycle_count), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Program: what the core retires on cycle k after the start edge.
    bit              s_valid [MAXC];
    logic [XLEN-1:0] s_pc    [MAXC];
    bit              s_we    [MAXC];
    logic [RW-1:0]   s_rd    [MAXC];
    logic [XLEN-1:0] s_data  [MAXC];
    bit              s_halt  [MAXC];

    bit              t_en  [NUM_CHECKS];
    logic [RW-1:0]   t_rd  [NUM_CHECKS];
    logic [XLEN-1:0] t_val [NUM_CHECKS];

    bit              e_done, e_pass, e_timeout;
    int              e_pcnt, e_fcnt, e_ffi, e_lat;
    logic [XLEN-1:0] e_ffa;
    longint          e_cyc, e_ret;
    bit              cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("done", done, e_done);
            check("pass", pass, e_pass);
            check("timeout", timeout, e_timeout);
            check("pass_count", pass_count, e_pcnt);
            check("fail_count", fail_count, e_fcnt);
            check("first_fail_idx", first_fail_idx, e_ffi);
            check("first_fail_actual", first_fail_actual, e_ffa);
            check("cycle_count", cycle_count, e_cyc);
            check("retire_count", retire_count, e_ret);
        end
    end

    task automatic zero_expect();
        e_done = 0; e_pass = 0; e_timeout = 0; e_pcnt = 0; e_fcnt = 0;
        e_ffi = 0; e_ffa = '0; e_cyc = 0; e_ret = 0; e_lat = 0;
    endtask

    // Reference: replay the program against an architectural register array,
    // find the halt cycle, and score the table once the drain window closes.
    task automatic model_run();
        logic [XLEN-1:0] sh [NUM_REGS];
        logic [XLEN-1:0] lp = '0;
        bit lpv = 0;
        int h = -1;
        for (int i = 0; i < NUM_REGS; i++) sh[i] = '0;
        zero_expect();
        for (int k = 0; k < MAXC; k++) begin
            if (h < 0 && k >= TIMEOUT_CYCLES) break;
            if (h >= 0 && k > h + DRAIN_CYCLES) break;
            if (s_valid[k]) begin
                e_ret++;
                if (s_we[k] && s_rd[k] != 0) sh[s_rd[k]] = s_data[k];
                if (h < 0 && (s_halt[k] || (lpv && s_pc[k] == lp))) h = k;
                lp = s_pc[k];
                lpv = 1;
            end
        end
        e_done = 1;
        if (h < 0) begin
            e_timeout = 1;
            e_cyc = TIMEOUT_CYCLES;
            e_lat = TIMEOUT_CYCLES;
        end else begin
            e_cyc = h + 1 + DRAIN_CYCLES;
            e_lat = h + 1 + DRAIN_CYCLES + NUM_CHECKS;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (t_en[i]) begin
                    if (sh[t_rd[i]] == t_val[i]) e_pcnt++;
                    else begin
                        if (e_fcnt == 0) begin e_ffi = i; e_ffa = sh[t_rd[i]]; end
                        e_fcnt++;
                    end
                end
            end
            e_pass = (e_fcnt == 0) && (e_pcnt > 0);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            s_valid[k] = 0; s_pc[k] = '0; s_we[k] = 0; s_rd[k] = '0; s_data[k] = '0; s_halt[k] = 0;
        end
    endtask

    task automatic put(input int k, input logic [XLEN-1:0] pc, input bit we, input int rd,
                       input logic [XLEN-1:0] data, input bit halt);
        s_valid[k] = 1; s_pc[k] = pc; s_we[k] = we; s_rd[k] = RW'(rd); s_data[k] = data; s_halt[k] = halt;
    endtask

    task automatic drive_idle();
        wb_valid = 0; wb_pc = '0; wb_we = 0; wb_rd = '0; wb_data = '0; wb_halt = 0;
    endtask

    task automatic drive(input int k);
        wb_valid = s_valid[k]; wb_pc = s_pc[k]; wb_we = s_we[k];
        wb_rd = s_rd[k]; wb_data = s_data[k]; wb_halt = s_halt[k];
    endtask

    task automatic load_entry(input int idx, input bit en, input int rd, input logic [XLEN-1:0] val);
        @(negedge clk);
        exp_we = 1; exp_idx = IW'(idx); exp_en = en; exp_rd = RW'(rd); exp_val = val;
        @(negedge clk);
        exp_we = 0;
        t_en[idx] = en; t_rd[idx] = RW'(rd); t_val[idx] = val;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NUM_CHECKS; i++) load_entry(i, 0, 0, '0);
    endtask

    // Runs the loaded program to completion; start_again_at re-pulses start on that cycle.
    task automatic run_prog(input int start_again_at);
        int lat = 0;
        bit seen = 0;
        model_run();
        cmp_en = 0;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        for (int k = 0; k < MAXC && !seen; k++) begin
            #1;
            start = (k == start_again_at);
            drive(k);
            @(posedge clk);
            #1;
            if (done) begin seen = 1; lat = k + 1; end
        end
        start = 0;
        drive_idle();
        check("done_latency", lat, e_lat);
        cmp_en = 1;
    endtask

    task automatic apply_reset();
        cmp_en = 0;
        #3 reset = 0;
        #1;
        check("rst_async_cycle_count", cycle_count, 0);
        check("rst_async_retire_count", retire_count, 0);
        check("rst_async_done", done, 0);
        start = 0; exp_we = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1;
        for (int i = 0; i < NUM_CHECKS; i++) begin t_en[i] = 0; t_rd[i] = '0; t_val[i] = '0; end
        zero_expect();
        cmp_en = 1;
    endtask

    initial begin
        int len;
        logic [XLEN-1:0] lastpc, p;
        bit have;

        reset = 0; start = 0; exp_we = 0; exp_en = 0; exp_idx = '0; exp_rd = '0; exp_val = '0;
        drive_idle();
        zero_expect();
        clear_stim();
        for (int i = 0; i < NUM_CHECKS; i++) begin t_en[i] = 0; t_rd[i] = '0; t_val[i] = '0; end
        repeat (3) @(negedge clk);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_cycle_count", cycle_count, 0);
        reset = 1;
        cmp_en = 1;
        repeat (2) @(negedge clk);

        // 1: four writes then ecall, all expectations match
        clear_stim();
        put(0, 32'h0, 1, 5, 10, 0); put(1, 32'h4, 1, 6, 20, 0);
        put(2, 32'h8, 1, 7, 30, 0); put(3, 32'hc, 1, 8, 10, 0);
        put(4, 32'h10, 0, 0, 0, 1);
        load_entry(0, 1, 5, 10); load_entry(1, 1, 6, 20);
        load_entry(2, 1, 7, 30); load_entry(3, 1, 8, 10);
        run_prog(-1);
        check("t1_pass", pass, 1);
        check("t1_pass_count", pass_count, 4);
        check("t1_fail_count", fail_count, 0);
        check("t1_cycle_count", cycle_count, 13);
        check("t1_retire_count", retire_count, 5);

        // 2: entry 2 now expects 31
        load_entry(2, 1, 7, 31);
        run_prog(-1);
        check("t2_pass", pass, 0);
        check("t2_fail_count", fail_count, 1);
        check("t2_first_fail_idx", first_fail_idx, 2);
        check("t2_first_fail_actual", first_fail_actual, 30);

        // 3: self-loop halt, write inside DRAIN kept, write after DRAIN dropped
        clear_table();
        clear_stim();
        put(0, 32'h40, 0, 0, 0, 0); put(1, 32'h40, 0, 0, 0, 0);
        put(4, 32'h44, 1, 29, 170, 0); put(10, 32'h48, 1, 28, 5, 0);
        load_entry(0, 1, 29, 170); load_entry(1, 1, 28, 0);
        run_prog(-1);
        check("t3_pass", pass, 1);
        check("t3_pass_count", pass_count, 2);
        check("t3_cycle_count", cycle_count, 10);
        check("t3_retire_count", retire_count, 3);

        // 4: no halt -> timeout
        clear_stim();
        for (int k = 0; k < MAXC; k++) put(k, 32'h1000 + 4 * k, (k % 3) == 0, (k % 31) + 1, k, 0);
        run_prog(-1);
        check("t4_timeout", timeout, 1);
        check("t4_cycle_count", cycle_count, 50);
        check("t4_pass", pass, 0);
        check("t4_pass_count", pass_count, 0);
        check("t4_retire_count", retire_count, 50);

        // 5: x0 write dropped; start during CHECK ignored
        clear_table();
        clear_stim();
        put(0, 32'h200, 1, 0, 32'hDEADBEEF, 0); put(1, 32'h204, 0, 0, 0, 1);
        load_entry(0, 1, 0, 0);
        run_prog(1 + DRAIN_CYCLES + 3);
        check("t5_pass", pass, 1);
        check("t5_pass_count", pass_count, 1);

        // 6: reset during DRAIN, restart with the table wiped
        clear_stim();
        put(0, 32'h100, 1, 5, 1, 1); put(2, 32'h104, 1, 6, 2, 0);
        cmp_en = 0;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            start = 0;
            drive(k);
            @(posedge clk);
        end
        apply_reset();
        repeat (2) @(negedge clk);
        run_prog(-1);
        check("t6_pass", pass, 0);
        check("t6_pass_count", pass_count, 0);
        check("t6_done", done, 1);

        // Random programs and tables
        for (int r = 0; r < 10; r++) begin
            clear_stim();
            len = $urandom_range(3, 45);
            lastpc = ($urandom & 32'hffff_fffc) - 4;
            have = 0;
            for (int k = 0; k < MAXC; k++) begin
                if ($urandom_range(0, 3) == 0) continue;
                if (have && k < len && $urandom_range(0, 19) == 0) p = lastpc;
                else p = lastpc + 4;
                put(k, p, $urandom_range(0, 2) != 0, $urandom_range(0, NUM_REGS - 1),
                    $urandom_range(0, 7), (k == len - 1) && ($urandom_range(0, 4) != 0));
                lastpc = p;
                have = 1;
            end
            for (int i = 0; i < NUM_CHECKS; i++)
                load_entry(i, $urandom_range(0, 3) != 0, $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 7));
            run_prog(-1);
            repeat (2) @(negedge clk);
        end

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
